muldiv_unit: RTL and testbench

- Parametrised, iterative integer multiply/divide execution unit for the RV M-extension; the next generation of the ALU decode path.
- Decodes funct3 into the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in EX and stalls the pipeline through a valid/ready handshake.
- Computes one result bit per cycle.

---
 rtl/muldiv_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative integer multiply/divide unit for the RISC-V M extension. It sits
// beside the single-cycle ALU in EX and stalls the pipeline through a
// valid/ready handshake. It produces one result bit per cycle.
//
// Multiply is a shift-add over a 2*XLEN accumulator. Divide is a restoring
// divider with an XLEN+1-bit partial remainder. Both run on operand
// magnitudes. The sign is put back in a single ADJ cycle. A divide by zero
// and the signed-overflow case skip the iteration and finish on the
// accept edge.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   request strobe, sampled only while o_ready=1
//   i_funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM,    111 REMU
//   i_rs1     operand A (multiplicand / dividend)
//   i_rs2     operand B (multiplier / divisor)
//   i_ack     consumer takes the result (meaningful while o_valid=1)
//   i_kill    synchronous flush; wins over i_valid and i_ack
//   o_ready   unit idle, can take a request
//   o_valid   o_result holds a finished result
//   o_result  result; forced to zero whenever o_valid=0
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_ack,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ADJ,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            state_q;
    state_t            state_d;

    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN:0]     hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_res_q;
    logic              neg_a_q;
    logic [XLEN-1:0]   result_q;

    logic              rs1_signed;
    logic              rs2_signed;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_adj;
    logic [XLEN-1:0]   quot_adj;
    logic [XLEN-1:0]   rem_raw;
    logic [XLEN-1:0]   rem_adj;
    logic [XLEN-1:0]   adj_res;

    // -----------------------------------------------------------------------
    // Request decode. Work out the operand signedness and magnitudes, and
    // spot the cases whose result is known without iterating. Negating the
    // most-negative value wraps back to itself, and read as unsigned that
    // is 2^(XLEN-1), which is the magnitude we want.
    // -----------------------------------------------------------------------
    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
            end
            3'b010:  rs1_signed = 1'b1;
            default: ;
        endcase
    end

    assign rs1_neg  = rs1_signed & i_rs1[XLEN-1];
    assign rs2_neg  = rs2_signed & i_rs2[XLEN-1];
    assign rs1_mag  = rs1_neg ? -i_rs1 : i_rs1;
    assign rs2_mag  = rs2_neg ? -i_rs2 : i_rs2;

    assign div_zero = i_funct3[2] && (i_rs2 == '0);
    assign div_ovf  = i_funct3[2] && !i_funct3[0] &&
                      (i_rs1 == MIN_VAL) && (i_rs2 == '1);
    assign special  = div_zero | div_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = i_funct3[1] ? i_rs1 : '1;
        end else if (div_ovf) begin
            special_res = i_funct3[1] ? '0 : i_rs1;
        end
    end

    // -----------------------------------------------------------------------
    // One iteration step.
    // Multiply: lo_q holds the multiplier bits that are still unused. The
    // multiplicand is added into the upper half and the pair shifts right.
    // Divide: lo_q shifts the dividend out from its top bit and collects
    // quotient bits at its bottom. hi_q is the partial remainder. hi_q[XLEN]
    // stays zero in both modes.
    // -----------------------------------------------------------------------
    assign mul_sum   = hi_q + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});

    // -----------------------------------------------------------------------
    // Sign correction and result selection in the ADJ cycle. The quotient
    // takes the sign from the XOR of the operand signs. The remainder takes
    // the sign of the dividend.
    // -----------------------------------------------------------------------
    assign prod     = {hi_q[XLEN-1:0], lo_q};
    assign prod_adj = neg_res_q ? -prod : prod;
    assign quot_adj = neg_res_q ? -lo_q : lo_q;
    assign rem_raw  = hi_q[XLEN-1:0];
    assign rem_adj  = neg_a_q ? -rem_raw : rem_raw;

    always_comb begin
        adj_res = rem_adj;
        case (funct3_q)
            3'b000:                 adj_res = prod_adj[XLEN-1:0];
            3'b001, 3'b010, 3'b011: adj_res = prod_adj[2*XLEN-1:XLEN];
            3'b100, 3'b101:         adj_res = quot_adj;
            default:                adj_res = rem_adj;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A kill takes priority over everything else and
    // sends the unit back to IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (i_kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (i_valid) state_d = special ? S_DONE : S_CALC;
                S_CALC: if (cnt_q == LAST_CNT) state_d = S_ADJ;
                S_ADJ:  state_d = S_DONE;
                S_DONE: if (i_ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. o_result is gated so it reads zero outside DONE.
    // -----------------------------------------------------------------------
    always_comb begin
        o_ready  = (state_q == S_IDLE);
        o_valid  = (state_q == S_DONE);
        o_result = o_valid ? result_q : '0;
    end

    // -----------------------------------------------------------------------
    // Datapath registers. Operands are captured only on the accept edge.
    // After that the inputs may change freely while the unit iterates.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            funct3_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid && !i_kill) begin
                        funct3_q  <= i_funct3;
                        neg_res_q <= rs1_neg ^ rs2_neg;
                        neg_a_q   <= rs1_neg;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        if (i_funct3[2]) begin
                            lo_q   <= rs1_mag;
                            opnd_q <= rs2_mag;
                        end else begin
                            lo_q   <= rs2_mag;
                            opnd_q <= rs1_mag;
                        end
                        if (special) begin
                            result_q <= special_res;
                        end
                    end
                end
                S_CALC: begin
                    if (!i_kill) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (funct3_q[2]) begin
                            hi_q <= div_ge ? div_diff : div_shift;
                            lo_q <= {lo_q[XLEN-2:0], div_ge};
                        end else begin
                            hi_q <= {1'b0, mul_sum[XLEN:1]};
                            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                        end
                    end
                end
                S_ADJ: begin
                    if (!i_kill) begin
                        result_q <= adj_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Testbench for muldiv_unit with two instances, XLEN=32 and XLEN=8. It
// drives directed vectors, corner vectors and random operations. The
// expected results come from plain wide-integer arithmetic. One compare
// process checks both result buses on every cycle: a held result must match
// the armed expectation, and an idle bus must read zero.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk;
    logic        rst32_n;
    logic        rst8_n;

    logic        valid32;
    logic [2:0]  f3_32;
    logic [31:0] rs1_32;
    logic [31:0] rs2_32;
    logic        ack32;
    logic        kill32;
    logic        rdy32;
    logic        ov32;
    logic [31:0] res32;

    logic        valid8;
    logic [2:0]  f3_8;
    logic [7:0]  rs1_8;
    logic [7:0]  rs2_8;
    logic        ack8;
    logic        kill8;
    logic        rdy8;
    logic        ov8;
    logic [7:0]  res8;

    int          n_checks;
    int          n_fail;

    logic        armed32;
    logic        armed8;
    logic [31:0] exp32;
    logic [31:0] exp8;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t dir_vec [12];

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .i_clk    (clk),
        .i_rst_n  (rst32_n),
        .i_valid  (valid32),
        .i_funct3 (f3_32),
        .i_rs1    (rs1_32),
        .i_rs2    (rs2_32),
        .i_ack    (ack32),
        .i_kill   (kill32),
        .o_ready  (rdy32),
        .o_valid  (ov32),
        .o_result (res32)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .i_clk    (clk),
        .i_rst_n  (rst8_n),
        .i_valid  (valid8),
        .i_funct3 (f3_8),
        .i_rs1    (rs1_8),
        .i_rs2    (rs2_8),
        .i_ack    (ack8),
        .i_kill   (kill8),
        .o_ready  (rdy8),
        .o_valid  (ov8),
        .o_result (res8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss.
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference result, computed with wide signed arithmetic at width xl.
    function automatic logic [31:0] ref_result(input logic [2:0] f,
                                               input logic [31:0] a_in,
                                               input logic [31:0] b_in,
                                               input int xl);
        logic [31:0]         mask;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [31:0]         min_v;
        logic signed [127:0] ua;
        logic signed [127:0] ub;
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        logic signed [127:0] r;
        mask  = (xl == 32) ? 32'hFFFF_FFFF : ((32'h1 << xl) - 32'h1);
        a     = a_in & mask;
        b     = b_in & mask;
        min_v = 32'h1 << (xl - 1);
        ua    = $signed({96'b0, a});
        ub    = $signed({96'b0, b});
        sa    = a[xl-1] ? ua - (128'sd1 <<< xl) : ua;
        sb    = b[xl-1] ? ub - (128'sd1 <<< xl) : ub;
        case (f)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> xl;
            3'd2: r = (sa * ub) >>> xl;
            3'd3: r = (ua * ub) >>> xl;
            3'd4: begin
                if (b == 0)                           r = -128'sd1;
                else if (a == min_v && b == mask)     r = sa;
                else                                  r = sa / sb;
            end
            3'd5: r = (b == 0) ? -128'sd1 : ua / ub;
            3'd6: begin
                if (b == 0)                           r = sa;
                else if (a == min_v && b == mask)     r = 128'sd0;
                else                                  r = sa % sb;
            end
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0] & mask;
    endfunction

    function automatic logic sel_ready(input bit s8);
        return s8 ? rdy8 : rdy32;
    endfunction

    function automatic logic sel_valid(input bit s8);
        return s8 ? ov8 : ov32;
    endfunction

    // Drive one instance's request-side inputs.
    task automatic apply_stimulus(input bit s8, input logic vld,
                                  input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic kill,
                                  input logic ack);
        if (s8) begin
            valid8 = vld;  f3_8 = f;  rs1_8 = a[7:0];  rs2_8 = b[7:0];
            kill8  = kill; ack8 = ack;
        end else begin
            valid32 = vld;  f3_32 = f;  rs1_32 = a;  rs2_32 = b;
            kill32  = kill; ack32 = ack;
        end
    endtask

    // One complete transaction: accept, latency, hold, ack.
    task automatic run_op(input bit s8, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int ack_delay);
        logic [31:0] mask;
        logic [31:0] minv;
        bit          special;
        int          exp_lat;
        int          lat;
        mask    = s8 ? 32'hFF : 32'hFFFF_FFFF;
        minv    = s8 ? 32'h80 : 32'h8000_0000;
        special = f[2] && (((b & mask) == 0) ||
                  (!f[0] && (a & mask) == minv && (b & mask) == mask));
        exp_lat = special ? 1 : (s8 ? 10 : 34);

        @(negedge clk);
        check_output("ready_before_req", 32'(sel_ready(s8)), 32'd1);
        if (s8) begin exp8 = exp_res; armed8 = 1'b1; end
        else    begin exp32 = exp_res; armed32 = 1'b1; end
        apply_stimulus(s8, 1'b1, f, a, b, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(s8, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                       1'b0, 1'b0);
        lat = 1;
        while (!sel_valid(s8) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_output("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i < ack_delay; i++) begin
            check_output("hold_not_ready", 32'(sel_ready(s8)), 32'd0);
            @(negedge clk);
        end
        apply_stimulus(s8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(s8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        if (s8) armed8 = 1'b0; else armed32 = 1'b0;
        check_output("ready_after_ack", 32'(sel_ready(s8)), 32'd1);
        check_output("valid_after_ack", 32'(sel_valid(s8)), 32'd0);
    endtask

    // Per-cycle compare of both result buses against the armed expectation.
    always @(negedge clk) begin
        if (ov32) begin
            check_output("valid32_expected", 32'(armed32), 32'd1);
            check_output("result32", res32, exp32);
        end else begin
            check_output("result32_idle_zero", res32, 32'd0);
        end
        check_output("ready_valid_excl32", 32'(rdy32 & ov32), 32'd0);
        if (ov8) begin
            check_output("valid8_expected", 32'(armed8), 32'd1);
            check_output("result8", 32'(res8), exp8);
        end else begin
            check_output("result8_idle_zero", 32'(res8), 32'd0);
        end
        check_output("ready_valid_excl8", 32'(rdy8 & ov8), 32'd0);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] corners [8];
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;

        n_checks = 0;
        n_fail   = 0;
        armed32  = 1'b0;
        armed8   = 1'b0;
        exp32    = '0;
        exp8     = '0;
        rst32_n  = 1'b0;
        rst8_n   = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        dir_vec[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        dir_vec[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        dir_vec[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        dir_vec[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir_vec[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        dir_vec[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        dir_vec[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        dir_vec[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        dir_vec[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        dir_vec[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        dir_vec[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        dir_vec[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

        corners = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFF};

        // Reset state of both instances.
        #12;
        check_output("reset_ready32",  32'(rdy32), 32'd1);
        check_output("reset_valid32",  32'(ov32),  32'd0);
        check_output("reset_result32", res32,      32'd0);
        check_output("reset_ready8",   32'(rdy8),  32'd1);
        check_output("reset_valid8",   32'(ov8),   32'd0);
        @(negedge clk);
        rst32_n = 1'b1;
        rst8_n  = 1'b1;

        // Directed 32-bit vectors, pinning the model to literal values too.
        for (int i = 0; i < 12; i++) begin
            check_output("model_pin", ref_result(dir_vec[i].f, dir_vec[i].a,
                                                 dir_vec[i].b, 32), dir_vec[i].e);
            run_op(1'b0, dir_vec[i].f, dir_vec[i].a, dir_vec[i].b,
                   dir_vec[i].e, (i == 0) ? 5 : i % 3);
        end

        // Kill during CALC cycle 10: no result, unit idle on the next edge.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 3'd0, 32'd9, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check_output("kill_ready", 32'(rdy32), 32'd1);
        check_output("kill_valid", 32'(ov32),  32'd0);
        repeat (40) @(negedge clk);
        check_output("model_pin_mul", ref_result(3'd0, 32'd3, 32'd4, 32), 32'd12);
        run_op(1'b0, 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // A request presented together with kill is dropped.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 3'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check_output("kill_drop_ready", 32'(rdy32), 32'd1);
        repeat (40) @(negedge clk);

        // Random 32-bit operations, biased toward the awkward operands.
        for (int i = 0; i < 100; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(1'b0, f, a, b, ref_result(f, a, b, 32), $urandom_range(0, 3));
        end

        // XLEN=8: every op over a grid of corner operands.
        for (int op = 0; op < 8; op++) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    run_op(1'b1, 3'(op), 32'(corners[i]), 32'(corners[j]),
                           ref_result(3'(op), 32'(corners[i]),
                                      32'(corners[j]), 8), 0);
                end
            end
        end
        check_output("model_pin8_div", ref_result(3'd4, 32'h80, 32'hFF, 8), 32'h80);
        check_output("model_pin8_mulh", ref_result(3'd1, 32'hFF, 32'hFF, 8), 32'h00);

        // XLEN=8: random operations.
        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            run_op(1'b1, f, a, b, ref_result(f, a, b, 8), $urandom_range(0, 2));
        end

        // XLEN=8: asynchronous reset in the middle of CALC.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 3'd3, 32'hC3, 32'h5A, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst8_n = 1'b0;
        #1;
        check_output("async_rst_ready8", 32'(rdy8), 32'd1);
        check_output("async_rst_valid8", 32'(ov8),  32'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(1'b1, 3'd0, 32'h0D, 32'h0B, ref_result(3'd0, 32'h0D, 32'h0B, 8), 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
